argon_control: RTL and testbench

Multi-cycle fetch/decode/control sequencer for the Argon CPU. It fetches 16-bit instruction words from instruction memory over a req/ack handshake and maintains the program counter. It decodes each instruction and drives the register-file and ALU control inputs of the Argon datapath: selects, write enable, ALU opcode, immediate path and writeback source. It sits directly upstream of the datapath and replaces the simulation-driven control inputs.

---
 rtl/argon_pkg.sv | 30 +++
 rtl/argon_decode.sv | 37 +++
 rtl/argon_control.sv | 151 +++++++++++++++
 tb/tb_argon_control.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argon_pkg.sv
// Shared definitions for the Argon fetch/decode/control sequencer:
// instruction class codes, field positions and the FSM state type.
package argon_pkg;

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_ALUR = 4'h1;
  localparam logic [3:0] CLS_ALUI = 4'h2;
  localparam logic [3:0] CLS_LDI  = 4'h3;
  localparam logic [3:0] CLS_JMP  = 4'h4;
  localparam logic [3:0] CLS_JZ   = 4'h5;
  localparam logic [3:0] CLS_HLT  = 4'hF;

  localparam int CLS_MSB = 15;
  localparam int CLS_LSB = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_FETCH_IMM,
    ST_EXECUTE,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/argon_decode.sv
// Combinational instruction decoder: splits IR into class and fields.
// Ports: ir in; cls/alu_op/rd/rb fields, needs_imm, writes_reg, illegal out.
module argon_decode
  import argon_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  cls,
  output logic [3:0]  alu_op,
  output logic [3:0]  rd,
  output logic [3:0]  rb,
  output logic        needs_imm,
  output logic        writes_reg,
  output logic        illegal
);

  assign cls    = ir[CLS_MSB:CLS_LSB];
  assign alu_op = ir[OP_MSB:OP_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];

  always_comb begin
    needs_imm  = 1'b0;
    writes_reg = 1'b0;
    illegal    = 1'b0;
    case (cls)
      CLS_NOP, CLS_HLT: ;
      CLS_ALUR: writes_reg = 1'b1;
      CLS_ALUI, CLS_LDI: begin
        needs_imm  = 1'b1;
        writes_reg = 1'b1;
      end
      CLS_JMP, CLS_JZ: needs_imm = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/argon_control.sv
// Argon fetch/decode/control sequencer: fetches over req/ack, keeps pc,
// and drives regfile/ALU controls for one EXECUTE cycle per instruction.
module argon_control
  import argon_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_data,
  output logic        o_write_en,
  output logic [3:0]  o_selectA,
  output logic [3:0]  o_selectB,
  output logic [3:0]  o_selectW,
  output logic [3:0]  o_alu_op,
  output logic        o_use_immediate,
  output logic        o_write_to_regfile,
  output logic [15:0] o_portW,
  input  logic        i_flag_zero,
  output logic [15:0] o_pc,
  output logic        o_halted,
  output logic        o_illegal
);

  state_t state, state_n;
  logic [15:0] pc, pc_n, ir, imm;
  logic z, z_ld, ir_ld, imm_ld;
  logic stall, stall_n, req;
  logic [3:0] sel_a_q, sel_b_q, sel_w_q;

  logic [3:0] cls, op, rd, rb;
  logic needs_imm, writes_reg, illegal;

  argon_decode u_dec (
    .ir         (ir),
    .cls        (cls),
    .alu_op     (op),
    .rd         (rd),
    .rb         (rb),
    .needs_imm  (needs_imm),
    .writes_reg (writes_reg),
    .illegal    (illegal)
  );

  always_comb begin
    state_n            = state;
    pc_n               = pc;
    stall_n            = stall;
    req                = 1'b0;
    ir_ld              = 1'b0;
    imm_ld             = 1'b0;
    z_ld               = 1'b0;
    o_write_en         = 1'b0;
    o_alu_op           = 4'h0;
    o_use_immediate    = 1'b0;
    o_write_to_regfile = 1'b0;
    o_portW            = 16'h0000;
    o_illegal          = 1'b0;
    o_halted           = 1'b0;
    o_selectA          = sel_a_q;
    o_selectB          = sel_b_q;
    o_selectW          = sel_w_q;
    unique case (state)
      ST_FETCH: begin
        // a stalled FETCH releases only when i_halt drops
        if (stall) begin
          stall_n = i_halt;
        end else begin
          req = 1'b1;
          if (i_imem_ack) begin
            ir_ld   = 1'b1;
            pc_n    = pc + 16'd1;
            state_n = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        state_n = needs_imm ? ST_FETCH_IMM : ST_EXECUTE;
      end
      ST_FETCH_IMM: begin
        req = 1'b1;
        if (i_imem_ack) begin
          imm_ld  = 1'b1;
          pc_n    = pc + 16'd1;
          state_n = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_n    = ST_FETCH;
        o_write_en = writes_reg;
        o_illegal  = illegal;
        case (cls)
          CLS_ALUR, CLS_ALUI: begin
            o_selectA       = rd;
            o_selectB       = rb;
            o_selectW       = rd;
            o_alu_op        = op;
            z_ld            = 1'b1;
            o_use_immediate = (cls == CLS_ALUI);
            o_portW         = (cls == CLS_ALUI) ? imm : 16'h0000;
          end
          CLS_LDI: begin
            o_selectW          = rd;
            o_write_to_regfile = 1'b1;
            o_portW            = imm;
          end
          CLS_JMP: pc_n = imm;
          CLS_JZ:  pc_n = z ? imm : pc;
          CLS_HLT: state_n = ST_HALTED;
          default: ;
        endcase
        // i_halt is only looked at on the way into FETCH
        if (state_n == ST_FETCH) stall_n = i_halt;
      end
      ST_HALTED: o_halted = 1'b1;
      default: state_n = ST_FETCH;
    endcase
  end

  // req is forced low while reset is held, even though state is FETCH
  assign o_imem_req  = req & i_reset;
  assign o_imem_addr = pc;
  assign o_pc        = pc;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_FETCH;
      pc      <= 16'h0000;
      ir      <= 16'h0000;
      imm     <= 16'h0000;
      z       <= 1'b0;
      stall   <= 1'b0;
      sel_a_q <= 4'h0;
      sel_b_q <= 4'h0;
      sel_w_q <= 4'h0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      stall   <= stall_n;
      sel_a_q <= o_selectA;
      sel_b_q <= o_selectB;
      sel_w_q <= o_selectW;
      if (ir_ld)  ir  <= i_imem_data;
      if (imm_ld) imm <= i_imem_data;
      if (z_ld)   z   <= i_flag_zero;
    end
  end

endmodule

// File: tb/tb_argon_control.sv
// Self-checking bench for argon_control: memory responder with
// configurable wait states, fetch/write scoreboards, scenario tasks.
module tb_argon_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        write_en;
  logic [3:0]  sel_a, sel_b, sel_w, alu_op;
  logic        use_imm, wtr;
  logic [15:0] port_w;
  logic        flag_zero = 1'b0;
  logic [15:0] pc;
  logic        halted, illegal;

  typedef struct {
    logic [3:0]  a, b, w, op;
    logic        ui, wtr;
    logic [15:0] pw;
    bit          chk_ab;
  } wr_t;

  logic [15:0] mem [0:65535];
  int          mem_wait = 0;
  logic [15:0] exp_fetch[$];
  wr_t         exp_wr[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic        prev_req = 1'b0;

  argon_control dut (
    .i_clk              (clk),
    .i_reset            (rst_n),
    .i_halt             (halt),
    .o_imem_req         (imem_req),
    .o_imem_addr        (imem_addr),
    .i_imem_ack         (imem_ack),
    .i_imem_data        (imem_data),
    .o_write_en         (write_en),
    .o_selectA          (sel_a),
    .o_selectB          (sel_b),
    .o_selectW          (sel_w),
    .o_alu_op           (alu_op),
    .o_use_immediate    (use_imm),
    .o_write_to_regfile (wtr),
    .o_portW            (port_w),
    .i_flag_zero        (flag_zero),
    .o_pc               (pc),
    .o_halted           (halted),
    .o_illegal          (illegal)
  );

  always #5 clk = ~clk;

  // memory: ack after mem_wait cycles of held request
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (imem_req && wcnt >= mem_wait) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wcnt      = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt     = imem_req ? wcnt + 1 : 0;
      end
    end
  end

  // scoreboard: each new request and each write strobe pops an expectation
  always @(negedge clk) begin
    wr_t e;
    logic [15:0] ea;
    if (mon_en) begin
      if (imem_req && !prev_req) begin
        checks++;
        if (exp_fetch.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected addr=%h", imem_addr);
        end else begin
          ea = exp_fetch.pop_front();
          if (imem_addr !== ea) begin
            errors++;
            $display("FAIL fetch_addr got=%h exp=%h", imem_addr, ea);
          end
        end
      end
      if (write_en) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected selW=%h", sel_w);
        end else begin
          e = exp_wr.pop_front();
          if (sel_w !== e.w || alu_op !== e.op || use_imm !== e.ui ||
              wtr !== e.wtr || port_w !== e.pw ||
              (e.chk_ab && (sel_a !== e.a || sel_b !== e.b))) begin
            errors++;
            $display("FAIL write_ctrl got A%h B%h W%h op%h ui%b wtr%b pw%h exp A%h B%h W%h op%h ui%b wtr%b pw%h",
                     sel_a, sel_b, sel_w, alu_op, use_imm, wtr, port_w,
                     e.a, e.b, e.w, e.op, e.ui, e.wtr, e.pw);
          end
        end
      end
    end
    prev_req = imem_req;
  end

  task automatic setup();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    halt   = 1'b0;
    flag_zero = 1'b0;
    mem_wait  = 0;
    exp_fetch.delete();
    exp_wr.delete();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_to_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_wr(input logic [3:0] a, b, w, op, input logic ui,
                         input logic wt, input logic [15:0] pw,
                         input bit cab);
    wr_t e;
    e.a = a; e.b = b; e.w = w; e.op = op;
    e.ui = ui; e.wtr = wt; e.pw = pw; e.chk_ab = cab;
    exp_wr.push_back(e);
  endtask

  task automatic test_reset();
    int bad;
    setup();
    mem_wait = 3;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_req got=%0d high cycles exp=0", bad);
    end
    release_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 ||
        write_en !== 1'b0 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release got req=%b addr=%h we=%b pc=%h exp 1 0000 0 0000",
               imem_req, imem_addr, write_en, pc);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || halted !== 1'b0 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_req got req=%b exp=0", imem_req);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_req got=%b exp=0", imem_req);
    end
  endtask

  task automatic test_ldi();
    bit ok;
    int k;
    setup();
    mem[0] = 16'h3030;
    mem[1] = 16'h1234;
    mem[2] = 16'hF000;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'h0002);
    push_wr(4'h0, 4'h0, 4'h3, 4'h0, 1'b0, 1'b1, 16'h1234, 1'b0);
    mon_en = 1'b1;
    release_reset();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (write_en) break;
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL ldi_latency got=%0d exp=4", k);
    end
    run_to_halt(ok);
    checks++;
    if (!ok || exp_fetch.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL ldi_done got halted=%b fq=%0d wq=%0d exp 1 0 0",
               ok, exp_fetch.size(), exp_wr.size());
    end
  endtask

  task automatic test_alu_r();
    bit ok;
    int k;
    setup();
    mem[0] = 16'h1A21;
    mem[1] = 16'hF000;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    push_wr(4'h2, 4'h1, 4'h2, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b1);
    mon_en = 1'b1;
    release_reset();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (write_en) break;
    end
    checks++;
    if (k != 3 || pc !== 16'h0001) begin
      errors++;
      $display("FAIL alur_latency_pc got k=%0d pc=%h exp k=3 pc=0001", k, pc);
    end
    run_to_halt(ok);
    checks++;
    if (!ok || exp_fetch.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL alur_done got halted=%b fq=%0d wq=%0d exp 1 0 0",
               ok, exp_fetch.size(), exp_wr.size());
    end
  endtask

  task automatic test_jz(input logic zf);
    bit ok;
    setup();
    flag_zero = zf;
    mem[0]     = 16'h1000;
    mem[1]     = 16'h5000;
    mem[2]     = 16'h0040;
    mem[3]     = 16'hF000;
    mem[16'h40] = 16'hF000;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'h0002);
    exp_fetch.push_back(zf ? 16'h0040 : 16'h0003);
    push_wr(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b1);
    mon_en = 1'b1;
    release_reset();
    run_to_halt(ok);
    checks++;
    if (!ok || exp_fetch.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL jz_z%0b_done got halted=%b fq=%0d wq=%0d exp 1 0 0",
               zf, ok, exp_fetch.size(), exp_wr.size());
    end
  endtask

  task automatic test_wait_wrap();
    bit ok, bad, seen;
    int n;
    setup();
    mem_wait = 3;
    mem[0]      = 16'h4000;
    mem[1]      = 16'hFFFF;
    mem[16'hFFFF] = 16'h0000;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'hFFFF);
    exp_fetch.push_back(16'h0000);
    mon_en = 1'b1;
    release_reset();
    n = 0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin
        n++;
        if (imem_addr !== 16'h0000 || pc !== 16'h0000) bad = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    checks++;
    if (n != 4 || bad) begin
      errors++;
      $display("FAIL wait_stable got cycles=%0d unstable=%b exp 4 0", n, bad);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pc === 16'hFFFF) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL jmp_target got pc=%h exp=ffff", pc);
    end
    mem[0] = 16'hF000;
    run_to_halt(ok);
    checks++;
    if (!ok || pc !== 16'h0001 || exp_fetch.size() != 0) begin
      errors++;
      $display("FAIL wrap_done got halted=%b pc=%h fq=%0d exp 1 0001 0",
               ok, pc, exp_fetch.size());
    end
  endtask

  task automatic test_illegal_halt();
    int cnt, bad;
    logic [15:0] pc_at;
    setup();
    mem[0] = 16'h7000;
    mem[1] = 16'hF000;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    mon_en = 1'b1;
    release_reset();
    cnt = 0;
    pc_at = 16'hDEAD;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (illegal) begin
        cnt++;
        pc_at = pc;
      end
      if (halted) break;
    end
    checks++;
    if (cnt != 1 || pc_at !== 16'h0001) begin
      errors++;
      $display("FAIL illegal_pulse got cnt=%0d pc=%h exp 1 0001", cnt, pc_at);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 3)
          $display("FAIL halted_hold got req=%b halted=%b exp 0 1",
                   imem_req, halted);
      end
    end
    checks++;
    if (exp_fetch.size() != 0) begin
      errors++;
      $display("FAIL halt_fetches got left=%0d exp=0", exp_fetch.size());
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset got halted=%b exp=0", halted);
    end
  endtask

  task automatic test_halt_stall();
    bit ok, seen;
    int bad;
    setup();
    mem[0] = 16'h0000;
    mem[1] = 16'hF000;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    mon_en = 1'b1;
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pc === 16'h0001) begin
        seen = 1'b1;
        break;
      end
    end
    halt = 1'b1;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req !== 1'b0 || pc !== 16'h0001) bad++;
      @(negedge clk);
    end
    checks++;
    if (!seen || bad != 0) begin
      errors++;
      $display("FAIL stall_hold got seen=%b bad=%0d exp 1 0", seen, bad);
    end
    halt = 1'b0;
    run_to_halt(ok);
    checks++;
    if (!ok || exp_fetch.size() != 0) begin
      errors++;
      $display("FAIL stall_resume got halted=%b fq=%0d exp 1 0",
               ok, exp_fetch.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ldi();
    test_alu_r();
    test_jz(1'b1);
    test_jz(1'b0);
    test_wait_wrap();
    test_illegal_halt();
    test_halt_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
